store_aligner: RTL and testbench
================================

# store_aligner

Store-side counterpart to the load extractor: takes one store request (byte address, register data, size) from the core and issues word-aligned write beats with per-byte write masks to the data memory/MMIO port. Stores that cross a 32-bit word boundary are split into two beats. Sits between the execute/memory stage store path and the memory write port, with valid/ready handshakes on both sides.

## Interface
- No parameters (data width fixed at 32, 4 byte lanes).
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  store request present
- req_ready  output  1  request accepted when req_valid & req_ready
- req_addr  input  32  byte address
- req_data  input  32  store data, right-justified (byte in [7:0], half in [15:0])
- req_size  input  2  00 sw, 01 sh, 10 sb, 11 illegal
- mem_valid  output  1  beat present
- mem_ready  input  1  beat consumed when mem_valid & mem_ready
- mem_addr  output  32  word address of beat, [1:0] always 0
- mem_wdata  output  32  lane-positioned write data
- mem_wmask  output  4  byte enables, bit i = byte lane i ([8i+7:8i])
- mem_last  output  1  final beat of current request
- err  output  1  one-cycle pulse: illegal size accepted

## Operation
- States: IDLE, BEAT0, BEAT1.
- off = req_addr[1:0]; smask = 4'b1111 / 4'b0011 / 4'b0001 for sw/sh/sb; m8 = {4'b0, smask} << off (8 bits); d64 = {32'b0, req_data} << (8*off).
- split = (m8[7:4] != 0): sw with off 1..3, sh with off 3. sb never splits.
- Accept (IDLE or last-beat handshake): capture m8[7:4], d64[63:32], and base = {req_addr[31:2], 2'b00}; load mem_addr = base, mem_wdata = d64[31:0], mem_wmask = m8[3:0], mem_last = !split; go BEAT0, mem_valid = 1.
- BEAT0 handshake, split: mem_addr = base + 4 (32-bit wrap: 0xFFFFFFFC -> 0x00000000), mem_wdata = d64[63:32], mem_wmask = m8[7:4], mem_last = 1; go BEAT1.
- Last-beat handshake (BEAT0 non-split or BEAT1): if new request accepted same cycle, load it (back-to-back); else IDLE, mem_valid = 0.
- req_size 11: request accepted, no beat issued, err = 1 next cycle, state stays/returns IDLE.
- mem_wdata lanes outside mem_wmask are don't-care to memory but must equal d64 slices (zeros from shift) for deterministic checking.
- Outputs hold stable while mem_valid & !mem_ready.

## Timing
- Reset (rst_n low, async): state IDLE, mem_valid 0, mem_addr 0, mem_wdata 0, mem_wmask 0, mem_last 0, err 0; internal captures 0.
- req_ready = (state == IDLE) | (mem_valid & mem_ready & mem_last); combinational path mem_ready -> req_ready permitted; no path req_valid -> req_ready.
- Latency: request accepted in cycle N -> first beat mem_valid in N+1.
- Throughput: one beat per cycle with mem_ready held high; aligned stores sustain 1 request/cycle; split stores 1 request/2 cycles.
- mem_valid never drops without a handshake; mem_* never change while stalled.
- Reset mid-request (BEAT0/BEAT1): pending beats dropped, all outputs to reset values immediately; no partial second beat after rst_n deasserts.
- err pulses exactly one cycle per illegal request; an illegal request accepted on a last-beat handshake still lets that beat complete normally.

## Test plan
- sw addr 0x100, data 0xDEADBEEF, mem_ready=1 -> one beat: addr 0x100, wdata 0xDEADBEEF, wmask 1111, last 1, cycle after acceptance.
- sb addr 0x203, data 0x000000A5 -> one beat: addr 0x200, wdata 0xA5000000, wmask 1000, last 1.
- sh addr 0x307, data 0x00001234 -> beat0 addr 0x304, wdata 0x34000000, wmask 1000, last 0; beat1 addr 0x308, wdata 0x00000012, wmask 0001, last 1.
- sw addr 0xFFFFFFFE, data 0x11223344, mem_ready low 3 cycles -> beat0 (0xFFFFFFFC, 0x33440000, 1100) held stable 4 cycles; beat1 (0x00000000, 0x00001122, 0011); req_ready low throughout stall.
- req_size 11 then back-to-back sw stream of 4 aligned stores -> err one-cycle pulse, no beat; then 4 beats on 4 consecutive cycles.
- rst_n pulsed low while in BEAT1 stalled -> mem_valid 0 asynchronously, all outputs reset, next request after release handled normally.

Source files
------------

// File: rtl/store_aligner.sv
// Store aligner: turns a byte-addressed store into one or two word-aligned
// write beats with byte masks, splitting stores that straddle a word boundary.
module store_aligner (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_data,
   input  logic [1:0]  req_size,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   output logic        mem_last,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

   state_t      state_q, state_d;
   logic        mem_valid_q, mem_valid_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_wmask_q, mem_wmask_d;
   logic        mem_last_q, mem_last_d;
   logic        err_q, err_d;
   logic [3:0]  hi_mask_q, hi_mask_d;
   logic [31:0] hi_data_q, hi_data_d;
   logic [31:0] base_q, base_d;

   logic [1:0]  off;
   logic [3:0]  smask;
   logic [7:0]  m8;
   logic [63:0] d64;
   logic        split;
   logic        fire;
   logic        accept;

   assign fire      = mem_valid_q & mem_ready;
   assign req_ready = (state_q == IDLE) | (fire & mem_last_q);
   assign accept    = req_valid & req_ready;

   // Lane positioning of the incoming request; upper halves feed the second beat.
   always_comb begin
      off = req_addr[1:0];
      case (req_size)
         2'b00:   smask = 4'b1111;
         2'b01:   smask = 4'b0011;
         default: smask = 4'b0001;
      endcase
      m8    = {4'b0000, smask} << off;
      d64   = {32'b0, req_data} << {off, 3'b000};
      split = |m8[7:4];
   end

   always_comb begin
      state_d     = state_q;
      mem_valid_d = mem_valid_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wmask_d = mem_wmask_q;
      mem_last_d  = mem_last_q;
      err_d       = 1'b0;
      hi_mask_d   = hi_mask_q;
      hi_data_d   = hi_data_q;
      base_d      = base_q;

      if (state_q == BEAT0 && fire && !mem_last_q) begin
         state_d     = BEAT1;
         mem_addr_d  = base_q + 32'd4;
         mem_wdata_d = hi_data_q;
         mem_wmask_d = hi_mask_q;
         mem_last_d  = 1'b1;
      end else if (accept) begin
         if (req_size == 2'b11) begin
            // Illegal size: consumed without a beat, flagged for one cycle.
            err_d       = 1'b1;
            state_d     = IDLE;
            mem_valid_d = 1'b0;
         end else begin
            state_d     = BEAT0;
            mem_valid_d = 1'b1;
            base_d      = {req_addr[31:2], 2'b00};
            hi_mask_d   = m8[7:4];
            hi_data_d   = d64[63:32];
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_wdata_d = d64[31:0];
            mem_wmask_d = m8[3:0];
            mem_last_d  = !split;
         end
      end else if (fire) begin
         state_d     = IDLE;
         mem_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mem_valid_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wmask_q <= '0;
         mem_last_q  <= 1'b0;
         err_q       <= 1'b0;
         hi_mask_q   <= '0;
         hi_data_q   <= '0;
         base_q      <= '0;
      end else begin
         state_q     <= state_d;
         mem_valid_q <= mem_valid_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wmask_q <= mem_wmask_d;
         mem_last_q  <= mem_last_d;
         err_q       <= err_d;
         hi_mask_q   <= hi_mask_d;
         hi_data_q   <= hi_data_d;
         base_q      <= base_d;
      end
   end

   assign mem_valid = mem_valid_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wmask = mem_wmask_q;
   assign mem_last  = mem_last_q;
   assign err       = err_q;

endmodule

// File: tb/tb_store_aligner.sv
// Directed bench for store_aligner: aligned, sub-word, split, wrap, stall,
// illegal-size, back-to-back and mid-request reset cases.
module tb_store_aligner;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic [1:0]  req_size;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_last;
   logic        err;

   int errors = 0;
   int checks = 0;

   store_aligner dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_size  (req_size),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wmask (mem_wmask),
      .mem_last  (mem_last),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic l);
      chk({tag, ".valid"}, {31'b0, mem_valid}, 32'd1);
      chk({tag, ".addr"},  mem_addr, a);
      chk({tag, ".wdata"}, mem_wdata, d);
      chk({tag, ".wmask"}, {28'b0, mem_wmask}, {28'b0, m});
      chk({tag, ".last"},  {31'b0, mem_last}, {31'b0, l});
   endtask

   task automatic all_reset(input string tag);
      chk({tag, ".valid"}, {31'b0, mem_valid}, 32'd0);
      chk({tag, ".addr"},  mem_addr, 32'd0);
      chk({tag, ".wdata"}, mem_wdata, 32'd0);
      chk({tag, ".wmask"}, {28'b0, mem_wmask}, 32'd0);
      chk({tag, ".last"},  {31'b0, mem_last}, 32'd0);
      chk({tag, ".err"},   {31'b0, err}, 32'd0);
   endtask

   task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
      req_valid = 1'b1;
      req_addr  = a;
      req_data  = d;
      req_size  = s;
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_addr  = '0;
      req_data  = '0;
      req_size  = '0;
      mem_ready = 1'b1;
      #12;
      all_reset("reset");
      chk("reset.req_ready", {31'b0, req_ready}, 32'd1);
      rst_n = 1'b1;

      // sw aligned
      put(32'h0000_0100, 32'hDEAD_BEEF, 2'b00);
      step();
      req_valid = 1'b0;
      beat("sw", 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 1'b1);
      step();
      chk("sw.idle", {31'b0, mem_valid}, 32'd0);

      // sb at lane 3
      put(32'h0000_0203, 32'h0000_00A5, 2'b10);
      step();
      req_valid = 1'b0;
      beat("sb", 32'h0000_0200, 32'hA500_0000, 4'b1000, 1'b1);
      step();
      chk("sb.idle", {31'b0, mem_valid}, 32'd0);

      // sh crossing a word boundary
      put(32'h0000_0307, 32'h0000_1234, 2'b01);
      step();
      req_valid = 1'b0;
      beat("sh.b0", 32'h0000_0304, 32'h3400_0000, 4'b1000, 1'b0);
      chk("sh.b0.req_ready", {31'b0, req_ready}, 32'd0);
      step();
      beat("sh.b1", 32'h0000_0308, 32'h0000_0012, 4'b0001, 1'b1);
      step();
      chk("sh.idle", {31'b0, mem_valid}, 32'd0);

      // sw at top of address space, stalled three cycles, second beat wraps to 0
      put(32'hFFFF_FFFE, 32'h1122_3344, 2'b00);
      mem_ready = 1'b0;
      step();
      req_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) mem_ready = 1'b1;
         beat($sformatf("wrap.b0.c%0d", i), 32'hFFFF_FFFC, 32'h3344_0000, 4'b1100, 1'b0);
         chk($sformatf("wrap.c%0d.req_ready", i), {31'b0, req_ready}, 32'd0);
         step();
      end
      beat("wrap.b1", 32'h0000_0000, 32'h0000_1122, 4'b0011, 1'b1);
      step();
      chk("wrap.idle", {31'b0, mem_valid}, 32'd0);

      // illegal size, then four back-to-back aligned stores
      put(32'h0000_0500, 32'h5555_5555, 2'b11);
      step();
      chk("ill.err", {31'b0, err}, 32'd1);
      chk("ill.nobeat", {31'b0, mem_valid}, 32'd0);
      put(32'h0000_0600, 32'hA000_0000, 2'b00);
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("b2b%0d.err", k), {31'b0, err}, 32'd0);
         beat($sformatf("b2b%0d", k), 32'h0000_0600 + 32'(k) * 32'd4,
              32'hA000_0000 + 32'(k), 4'b1111, 1'b1);
         chk($sformatf("b2b%0d.req_ready", k), {31'b0, req_ready}, 32'd1);
         if (k < 3) put(32'h0000_0600 + 32'(k + 1) * 32'd4, 32'hA000_0000 + 32'(k + 1), 2'b00);
         else req_valid = 1'b0;
      end
      step();
      chk("b2b.idle", {31'b0, mem_valid}, 32'd0);

      // reset while second beat is stalled
      put(32'h0000_0307, 32'h0000_1234, 2'b01);
      step();
      req_valid = 1'b0;
      step();
      mem_ready = 1'b0;
      step();
      beat("rst.b1_stalled", 32'h0000_0308, 32'h0000_0012, 4'b0001, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      all_reset("rst.async");
      #2;
      rst_n = 1'b1;
      mem_ready = 1'b1;
      step();
      chk("rst.no_partial", {31'b0, mem_valid}, 32'd0);
      put(32'h0000_0040, 32'hCAFE_F00D, 2'b00);
      step();
      req_valid = 1'b0;
      beat("rst.after", 32'h0000_0040, 32'hCAFE_F00D, 4'b1111, 1'b1);
      step();
      chk("rst.after.idle", {31'b0, mem_valid}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
